// File: rtl/dpram_arbiter_if.sv
// Requester and RAM-side bundle for dpram_arbiter: four requester lanes plus one dual-port RAM.
// Latency: none. Backpressure: none, because requesters hold their request until they see gnt.
interface dpram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 64
);
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [3:0]      gnt;
    logic [3:0]      rvalid;
    logic [4*DW-1:0] rdata;
    logic [1:0]      ram_rw;
    logic [AW-1:0]   ram_addr_a;
    logic [AW-1:0]   ram_addr_b;
    logic [DW-1:0]   ram_din_a;
    logic [DW-1:0]   ram_din_b;
    logic [DW-1:0]   ram_dout_a;
    logic [DW-1:0]   ram_dout_b;

    modport slave (
        input  req, we, addr, wdata, ram_dout_a, ram_dout_b,
        output gnt, rvalid, rdata, ram_rw, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
    );

    modport master (
        output req, we, addr, wdata, ram_dout_a, ram_dout_b,
        input  gnt, rvalid, rdata, ram_rw, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
    );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter that grants up to two of four requesters onto dual-port RAM ports A and B. Optional macro DPRAM_ARB_STATS_EN adds the grant and conflict counters.
// Latency: gnt is combinational; RAM command is registered one cycle after the grant; read data returns two cycles after the grant.
// Backpressure: none. The pipeline never stalls, and a requester that is not granted simply keeps requesting.
module dpram_arbiter #(
    parameter int AW = 6,
    parameter int DW = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    dpram_arbiter_if.slave     bus
`ifdef DPRAM_ARB_STATS_EN
    ,
    output logic [15:0]        grant_count,
    output logic [15:0]        conflict_count
`endif
);

    logic [1:0]    ptr;
    logic          cand_a_vld, cand_b_vld;
    logic [1:0]    cand_a, cand_b, scan_idx, last_idx;
    logic [AW-1:0] addr_a_c, addr_b_c;
    logic [DW-1:0] wdata_a_c, wdata_b_c;
    logic          we_a_c, we_b_c, conflict, gnt_a, gnt_b;
    logic [3:0]    gnt_c;

    logic [1:0]    ram_rw_q;
    logic [AW-1:0] ram_addr_a_q, ram_addr_b_q;
    logic [DW-1:0] ram_din_a_q, ram_din_b_q;

    // Index 0 of each vector is port A and index 1 is port B.
    logic [1:0]    rd1_vld, rd2_vld;
    logic [1:0]    rd1_id_a, rd1_id_b, rd2_id_a, rd2_id_b;

    logic [3:0]      rvalid_c;
    logic [4*DW-1:0] rdata_c;

    always_comb begin
        cand_a_vld = 1'b0;
        cand_b_vld = 1'b0;
        cand_a     = '0;
        cand_b     = '0;
        scan_idx   = '0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (bus.req[scan_idx]) begin
                if (!cand_a_vld) begin
                    cand_a_vld = 1'b1;
                    cand_a     = scan_idx;
                end else if (!cand_b_vld) begin
                    cand_b_vld = 1'b1;
                    cand_b     = scan_idx;
                end
            end
        end
        addr_a_c  = bus.addr[cand_a*AW +: AW];
        addr_b_c  = bus.addr[cand_b*AW +: AW];
        wdata_a_c = bus.wdata[cand_a*DW +: DW];
        wdata_b_c = bus.wdata[cand_b*DW +: DW];
        we_a_c    = bus.we[cand_a];
        we_b_c    = bus.we[cand_b];
        // A second candidate that hits the same word as a write defers to the next scan.
        conflict  = cand_a_vld && cand_b_vld && (addr_a_c == addr_b_c) && (we_a_c || we_b_c);
        gnt_a     = rst_n && cand_a_vld;
        gnt_b     = rst_n && cand_b_vld && !conflict;
        gnt_c     = '0;
        if (gnt_a) gnt_c[cand_a] = 1'b1;
        if (gnt_b) gnt_c[cand_b] = 1'b1;
        last_idx  = gnt_b ? cand_b : cand_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            ram_rw_q     <= '0;
            ram_addr_a_q <= '0;
            ram_addr_b_q <= '0;
            ram_din_a_q  <= '0;
            ram_din_b_q  <= '0;
            rd1_vld      <= '0;
            rd2_vld      <= '0;
            rd1_id_a     <= '0;
            rd1_id_b     <= '0;
            rd2_id_a     <= '0;
            rd2_id_b     <= '0;
        end else begin
            if (gnt_a) ptr <= last_idx + 2'd1;
            ram_rw_q <= {gnt_b && we_b_c, gnt_a && we_a_c};
            if (gnt_a) begin
                ram_addr_a_q <= addr_a_c;
                ram_din_a_q  <= wdata_a_c;
            end
            if (gnt_b) begin
                ram_addr_b_q <= addr_b_c;
                ram_din_b_q  <= wdata_b_c;
            end
            rd1_vld  <= {gnt_b && !we_b_c, gnt_a && !we_a_c};
            rd1_id_a <= cand_a;
            rd1_id_b <= cand_b;
            rd2_vld  <= rd1_vld;
            rd2_id_a <= rd1_id_a;
            rd2_id_b <= rd1_id_b;
        end
    end

    // The RAM presents read data in the cycle after it samples the command, so route it straight through.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = '0;
        if (rd2_vld[0]) begin
            rvalid_c[rd2_id_a]             = 1'b1;
            rdata_c[rd2_id_a*DW +: DW]     = bus.ram_dout_a;
        end
        if (rd2_vld[1]) begin
            rvalid_c[rd2_id_b]             = 1'b1;
            rdata_c[rd2_id_b*DW +: DW]     = bus.ram_dout_b;
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.rvalid     = rvalid_c;
    assign bus.rdata      = rdata_c;
    assign bus.ram_rw     = ram_rw_q;
    assign bus.ram_addr_a = ram_addr_a_q;
    assign bus.ram_addr_b = ram_addr_b_q;
    assign bus.ram_din_a  = ram_din_a_q;
    assign bus.ram_din_b  = ram_din_b_q;

`ifdef DPRAM_ARB_STATS_EN
    logic [16:0] grant_sum;
    assign grant_sum = {1'b0, grant_count} + 17'(gnt_a) + 17'(gnt_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count    <= '0;
            conflict_count <= '0;
        end else begin
            grant_count <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
            if (conflict && conflict_count != 16'hFFFF)
                conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

endmodule
